// File: rtl/y86_seq_ctrl.sv
// y86_seq_ctrl: multi-cycle sequencer for the Y86 datapath.
// Steps each instruction through F, D, E, M, W and P. Each stage has a
// one-hot enable, and the fetch and data memory ports use ready handshakes.
// The Y86 status code is tracked here. The core parks in HALT on a halt
// instruction, an invalid icode, a memory fault or a memory timeout.
// Optional build macro: PERF_CNT_EN adds the cycle_cnt and inst_cnt counters.
module y86_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] icode,
  input  logic       rom_ready,
  input  logic       rom_error,
  input  logic       mem_ready,
  input  logic       mem_error,
  output logic       fetch_req,
  output logic       dec_en,
  output logic       exe_en,
  output logic       mem_req,
  output logic       mem_wr,
  output logic       wb_en,
  output logic       pc_en,
  output logic [2:0] stat,
  output logic       halted
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F    = 3'd1,
    S_D    = 3'd2,
    S_E    = 3'd3,
    S_M    = 3'd4,
    S_W    = 3'd5,
    S_P    = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // The last wait cycle before a stalled request becomes an address fault.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] stat_q, stat_d;
  logic [7:0] wait_q, wait_d;
  logic       wr_q, wr_d;

  // mrmovl, rmmovl, call, ret, push and pop all touch data memory.
  function automatic logic is_mem_op(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  // Instructions that write registers without a memory access.
  function automatic logic is_reg_op(input logic [3:0] ic);
    return ic inside {4'h2, 4'h3, 4'h6};
  endfunction

  // Memory instructions that also update a register after the access.
  function automatic logic mem_then_wb(input logic [3:0] ic);
    return ic inside {4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  // Store-type memory instructions: rmmovl, call and push.
  function automatic logic is_store(input logic [3:0] ic);
    return ic inside {4'h4, 4'h8, 4'hA};
  endfunction

  // State, status, wait counter and the latched write flag.
  // NOTE: registered state is updated with <= so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      wait_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic. It also handles fault capture and the timeout count.
  always_comb begin
    // NOTE: defaults come first so every path assigns every signal;
    // a missing branch would otherwise infer a latch.
    state_d = state_q;
    stat_d  = stat_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_F;
      S_F: begin
        if (rom_ready) begin
          if (rom_error) begin
            state_d = S_HALT;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_D;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_D: begin
        if (icode == 4'h0) begin
          state_d = S_HALT;
          stat_d  = STAT_HLT;
        end else if (icode > 4'hB) begin
          state_d = S_HALT;
          stat_d  = STAT_INS;
        end else begin
          state_d = S_E;
        end
      end
      S_E: begin
        if (is_mem_op(icode)) begin
          state_d = S_M;
          wr_d    = is_store(icode);
        end else if (is_reg_op(icode)) begin
          state_d = S_W;
        end else begin
          state_d = S_P;
        end
      end
      S_M: begin
        if (mem_ready) begin
          if (mem_error) begin
            state_d = S_HALT;
            stat_d  = STAT_ADR;
          end else begin
            state_d = mem_then_wb(icode) ? S_W : S_P;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_W:     state_d = S_P;
      S_P:     state_d = run ? S_F : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Each wait window starts fresh in the new state.
    if (state_d != state_q) wait_d = '0;
  end

  // Moore outputs: decoded only from registered state, never from inputs.
  always_comb begin
    fetch_req = (state_q == S_F);
    dec_en    = (state_q == S_D);
    exe_en    = (state_q == S_E);
    mem_req   = (state_q == S_M);
    mem_wr    = (state_q == S_M) && wr_q;
    wb_en     = (state_q == S_W);
    pc_en     = (state_q == S_P);
    halted    = (state_q == S_HALT);
    stat      = stat_q;
  end

`ifdef PERF_CNT_EN
  // Performance counters: active cycles and retired instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (state_q == S_P) inst_cnt <= inst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed testbench for y86_seq_ctrl. The DUT is built with MEM_TIMEOUT=4
// so that the timeout boundary is reached in a few cycles.
module tb_y86_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, rom_ready, rom_error, mem_ready, mem_error;
  logic [3:0] icode;
  logic       fetch_req, dec_en, exe_en, mem_req, mem_wr, wb_en, pc_en, halted;
  logic [2:0] stat;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, inst_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] EN_0 = 6'b000000;
  localparam logic [5:0] EN_F = 6'b100000;
  localparam logic [5:0] EN_D = 6'b010000;
  localparam logic [5:0] EN_E = 6'b001000;
  localparam logic [5:0] EN_M = 6'b000100;
  localparam logic [5:0] EN_W = 6'b000010;
  localparam logic [5:0] EN_P = 6'b000001;

  logic [5:0] en;
  assign en = {fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en};

  y86_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .icode(icode),
    .rom_ready(rom_ready), .rom_error(rom_error),
    .mem_ready(mem_ready), .mem_error(mem_error),
    .fetch_req(fetch_req), .dec_en(dec_en), .exe_en(exe_en),
    .mem_req(mem_req), .mem_wr(mem_wr), .wb_en(wb_en), .pc_en(pc_en),
    .stat(stat), .halted(halted)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; icode = 4'h1;
    rom_ready = 1'b0; rom_error = 1'b0; mem_ready = 1'b0; mem_error = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; icode = 4'h1;
    rom_ready = 1'b1; rom_error = 1'b0; mem_ready = 1'b1; mem_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (en !== EN_0 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL reset_enables: got %b/%b expected %b/0", en, mem_wr, EN_0);
    end
    checks++;
    if (stat !== 3'd1 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_stat: got stat=%0d halted=%b expected stat=1 halted=0", stat, halted);
    end
`ifdef PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd0 || inst_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", cycle_cnt, inst_cnt);
    end
`endif
    run = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (en !== EN_0) begin
      errors++; $display("FAIL idle_hold: got %b expected %b", en, EN_0);
    end
  endtask

  task automatic test_nop();
    logic [5:0] exp_seq [4];
    exp_seq = '{EN_F, EN_D, EN_E, EN_P};
    do_reset();
    icode = 4'h1; rom_ready = 1'b1; run = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (en !== exp_seq[i % 4] || stat !== 3'd1) begin
        errors++;
        $display("FAIL nop_cycle%0d: got en=%b stat=%0d expected en=%b stat=1", i, en, stat, exp_seq[i % 4]);
      end
      if (i == 7) run = 1'b0;
      step();
    end
    checks++;
    if (en !== EN_0 || halted !== 1'b0) begin
      errors++; $display("FAIL nop_idle: got en=%b halted=%b expected %b/0", en, halted, EN_0);
    end
`ifdef PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd8 || inst_cnt !== 32'd2) begin
      errors++; $display("FAIL nop_perf: got %0d/%0d expected 8/2", cycle_cnt, inst_cnt);
    end
`endif
  endtask

  task automatic test_mrmovl_wait();
    logic [5:0] exp_seq [9];
    exp_seq = '{EN_F, EN_D, EN_E, EN_M, EN_M, EN_M, EN_M, EN_W, EN_P};
    do_reset();
    icode = 4'h5; rom_ready = 1'b1; run = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      mem_ready = (i == 6);
      if (i == 1) run = 1'b0;
      checks++;
      if (en !== exp_seq[i]) begin
        errors++; $display("FAIL mrmovl_cycle%0d: got %b expected %b", i, en, exp_seq[i]);
      end
      if (exp_seq[i] == EN_M) begin
        checks++;
        if (mem_wr !== 1'b0) begin
          errors++; $display("FAIL mrmovl_wr%0d: got %b expected 0", i, mem_wr);
        end
      end
      step();
    end
    checks++;
    if (en !== EN_0 || stat !== 3'd1) begin
      errors++; $display("FAIL mrmovl_idle: got en=%b stat=%0d expected %b/1", en, stat, EN_0);
    end
  endtask

  task automatic test_push_run_drop();
    logic [5:0] exp_seq [6];
`ifdef PERF_CNT_EN
    logic [31:0] inst_before;
`endif
    exp_seq = '{EN_F, EN_D, EN_E, EN_M, EN_W, EN_P};
    do_reset();
    icode = 4'hA; rom_ready = 1'b1; mem_ready = 1'b1; run = 1'b1;
`ifdef PERF_CNT_EN
    inst_before = inst_cnt;
`endif
    step();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) run = 1'b0;
      checks++;
      if (en !== exp_seq[i]) begin
        errors++; $display("FAIL push_cycle%0d: got %b expected %b", i, en, exp_seq[i]);
      end
      if (i == 3) begin
        checks++;
        if (mem_wr !== 1'b1) begin
          errors++; $display("FAIL push_wr: got %b expected 1", mem_wr);
        end
      end
      step();
    end
    checks++;
    if (en !== EN_0) begin
      errors++; $display("FAIL push_idle: got %b expected %b", en, EN_0);
    end
`ifdef PERF_CNT_EN
    checks++;
    if (inst_cnt !== inst_before + 32'd1) begin
      errors++; $display("FAIL push_inst_cnt: got %0d expected %0d", inst_cnt, inst_before + 32'd1);
    end
`endif
  endtask

  task automatic test_halt_insn();
    do_reset();
    icode = 4'h0; rom_ready = 1'b1; run = 1'b1;
    step();
    checks++;
    if (en !== EN_F) begin
      errors++; $display("FAIL halt_fetch: got %b expected %b", en, EN_F);
    end
    step();
    checks++;
    if (en !== EN_D) begin
      errors++; $display("FAIL halt_decode: got %b expected %b", en, EN_D);
    end
    step();
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'b1;
      checks++;
      if (en !== EN_0 || halted !== 1'b1 || stat !== 3'd2) begin
        errors++;
        $display("FAIL halt_park%0d: got en=%b halted=%b stat=%0d expected %b/1/2", i, en, halted, stat, EN_0);
      end
      step();
    end
`ifdef PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd2 || inst_cnt !== 32'd0) begin
      errors++; $display("FAIL halt_perf_frozen: got %0d/%0d expected 2/0", cycle_cnt, inst_cnt);
    end
`endif
    rst = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || stat !== 3'd1 || en !== EN_0) begin
      errors++; $display("FAIL halt_rst: got halted=%b stat=%0d en=%b expected 0/1/%b", halted, stat, en, EN_0);
    end
    rst = 1'b0; run = 1'b0;
    step();
    checks++;
    if (en !== EN_0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_rst_idle: got en=%b halted=%b expected %b/0", en, halted, EN_0);
    end
  endtask

  task automatic test_faults();
    // Invalid instruction code.
    do_reset();
    icode = 4'hC; rom_ready = 1'b1; run = 1'b1;
    repeat (3) step();
    checks++;
    if (stat !== 3'd4 || halted !== 1'b1) begin
      errors++; $display("FAIL ins_fault: got stat=%0d halted=%b expected 4/1", stat, halted);
    end
    // Data memory error on an rmmovl.
    do_reset();
    icode = 4'h4; rom_ready = 1'b1; mem_ready = 1'b1; mem_error = 1'b1; run = 1'b1;
    repeat (4) step();
    checks++;
    if (en !== EN_M || mem_wr !== 1'b1) begin
      errors++; $display("FAIL rmmovl_mem: got en=%b wr=%b expected %b/1", en, mem_wr, EN_M);
    end
    step();
    checks++;
    if (stat !== 3'd3 || halted !== 1'b1 || en !== EN_0) begin
      errors++; $display("FAIL mem_fault: got stat=%0d halted=%b en=%b expected 3/1/%b", stat, halted, en, EN_0);
    end
    // Instruction fetch error.
    do_reset();
    icode = 4'h1; rom_ready = 1'b1; rom_error = 1'b1; run = 1'b1;
    repeat (2) step();
    checks++;
    if (stat !== 3'd3 || halted !== 1'b1) begin
      errors++; $display("FAIL rom_fault: got stat=%0d halted=%b expected 3/1", stat, halted);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    icode = 4'h1; rom_ready = 1'b0; run = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (en !== EN_F) begin
        errors++; $display("FAIL timeout_fetch%0d: got %b expected %b", i, en, EN_F);
      end
      step();
    end
    checks++;
    if (halted !== 1'b1 || stat !== 3'd3 || en !== EN_0) begin
      errors++; $display("FAIL timeout_fault: got halted=%b stat=%0d en=%b expected 1/3/%b", halted, stat, en, EN_0);
    end
    // Ready on the last permitted cycle wins over the timeout.
    do_reset();
    icode = 4'h1; rom_ready = 1'b0; run = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      rom_ready = (i == 3);
      checks++;
      if (en !== EN_F) begin
        errors++; $display("FAIL edge_fetch%0d: got %b expected %b", i, en, EN_F);
      end
      step();
    end
    checks++;
    if (en !== EN_D || stat !== 3'd1 || halted !== 1'b0) begin
      errors++; $display("FAIL edge_ready_wins: got en=%b stat=%0d halted=%b expected %b/1/0", en, stat, halted, EN_D);
    end
    run = 1'b0;
    repeat (3) step();
    checks++;
    if (en !== EN_0 || stat !== 3'd1) begin
      errors++; $display("FAIL edge_idle: got en=%b stat=%0d expected %b/1", en, stat, EN_0);
    end
  endtask

  // A fetch wait and then a memory wait in the same instruction, followed by
  // a second instruction. This needs the wait counter to restart per state.
  task automatic test_back_to_back();
    logic [5:0] exp_seq [18];
    exp_seq = '{EN_F, EN_F, EN_F, EN_F, EN_D, EN_E, EN_M, EN_M, EN_M, EN_M, EN_W, EN_P,
                EN_F, EN_D, EN_E, EN_M, EN_W, EN_P};
    do_reset();
    icode = 4'h5; run = 1'b1;
    step();
    for (int i = 0; i < 18; i++) begin
      rom_ready = !(i < 3);
      mem_ready = !(i >= 6 && i <= 8);
      if (i == 12) run = 1'b0;
      checks++;
      if (en !== exp_seq[i] || stat !== 3'd1) begin
        errors++; $display("FAIL b2b_cycle%0d: got en=%b stat=%0d expected en=%b stat=1", i, en, stat, exp_seq[i]);
      end
      step();
    end
    checks++;
    if (en !== EN_0 || halted !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got en=%b halted=%b expected %b/0", en, halted, EN_0);
    end
`ifdef PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd18 || inst_cnt !== 32'd2) begin
      errors++; $display("FAIL b2b_perf: got %0d/%0d expected 18/2", cycle_cnt, inst_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_nop();
    test_mrmovl_wait();
    test_push_run_drop();
    test_halt_insn();
    test_faults();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
- Multi-cycle sequencer for the Y86 datapath (pc_reg, if_id, id and the downstream execute/memory/writeback blocks).
- Steps each instruction through Fetch, Decode, Execute, Memory, Writeback and PC-update, emitting one-hot stage enables.
- Handshakes with instruction and data memory.
- Tracks the Y86 status code and parks the core on halt, invalid instruction or memory fault.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request may wait for ready before ADR fault; legal 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- run  in  1  allow sequencing; sampled in IDLE and P
- icode  in  4  instruction code from id, valid in D
- rom_ready  in  1  instruction word valid this cycle
- rom_error  in  1  instruction fetch fault, qualified by rom_ready
- mem_ready  in  1  data memory access complete this cycle
- mem_error  in  1  data memory fault, qualified by mem_ready
- fetch_req  out  1  instruction fetch request
- dec_en  out  1  decode stage enable
- exe_en  out  1  execute stage enable
- mem_req  out  1  data memory request
- mem_wr  out  1  data memory write (valid with mem_req)
- wb_en  out  1  register writeback enable
- pc_en  out  1  PC update enable
- stat  out  3  Y86 status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- halted  out  1  core parked

Behaviour:
- One clock; reset is asynchronous and active-high via rst. While rst=1: state=IDLE, wait_cnt=0, all enables 0, halted=0, stat=1 (AOK).
- Moore outputs decoded from the state register; no input-to-output combinational paths.
- States: IDLE, F, D, E, M, W, P, HALT (3-bit encoding).
- IDLE: all enables 0. run=1 -> F, else stay.
- F: fetch_req=1.
  - rom_ready=1, rom_error=0 -> D.
  - rom_ready=1, rom_error=1 -> HALT, stat=3.
  - rom_ready=0 -> stay, wait_cnt++.
- D: dec_en=1 for exactly one cycle.
  - icode=0 -> HALT, stat=2.
  - icode>4'hB -> HALT, stat=4.
  - Otherwise -> E.
- E: exe_en=1 for one cycle.
  - Memory ops (icode 4,5,8,9,A,B) -> M.
  - Else register writers (2,3,6) -> W.
  - Else (1 nop, 7 jXX) -> P.
- M: mem_req=1; mem_wr=1 for icode 4, 8, A, else 0. icode is held stable by id for the whole instruction.
  - mem_ready=1, mem_error=0 -> W if icode in {5,8,9,A,B}, else P.
  - mem_ready=1, mem_error=1 -> HALT, stat=3.
  - mem_ready=0 -> stay, wait_cnt++.
- W: wb_en=1 for one cycle -> P.
- P: pc_en=1 for one cycle -> F if run=1, else IDLE.
- HALT: halted=1, all enables 0, stat frozen. Exit only via rst.
- Timeout (wait_cnt, 8-bit):
  - Cleared on every state change.
  - In F or M with ready low and wait_cnt==MEM_TIMEOUT-1 -> HALT, stat=3.
  - Ready arriving on that same cycle wins: normal transition, no fault.
- Minimum latency with ready asserted on first cycle:
  - nop/jXX: 4 cycles (F,D,E,P).
  - rrmovl/irmovl/OPl: 5 cycles.
  - rmmovl: 5 cycles.
  - mrmovl/call/ret/push/pop: 6 cycles.
- run dropping mid-instruction does not abort; the instruction completes through P, then the FSM enters IDLE.
- rst mid-operation: immediate return to reset values regardless of state, including HALT.
- Exactly one enable among fetch_req, dec_en, exe_en, mem_req, wb_en, pc_en is high in any cycle; none are high in IDLE and HALT.

Optional Feature:
- PERF_CNT_EN: when defined, add outputs cycle_cnt (32-bit) and inst_cnt (32-bit).
  - cycle_cnt increments every cycle state!=IDLE and !=HALT.
  - inst_cnt increments on every P cycle.
  - Both reset to 0 and wrap modulo 2^32; both frozen in HALT.
- Without PERF_CNT_EN: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, run=1, rom_ready=1, icode=1 (nop) -> fetch_req, dec_en, exe_en, pc_en each high one cycle in order; repeats every 4 cycles; stat=1.
- icode=5 (mrmovl), mem_ready held low 3 cycles then high -> mem_req high 4 cycles, mem_wr=0, then wb_en one cycle, then pc_en; 9 cycles total.
- icode=0 after fetch -> HALT entered after D; halted=1, stat=2; enables stay 0 for 20 cycles; rst pulse -> IDLE, stat=1.
- icode=4'hC -> stat=4, halted=1 after D; icode=4 with mem_error=1 on mem_ready -> stat=3, halted=1.
- MEM_TIMEOUT=4, rom_ready stuck 0 -> fetch_req high exactly 4 cycles, then HALT, stat=3. Repeat with rom_ready rising on 4th cycle -> D entered, no fault.
- run drops during M of icode=A (push) -> mem_wr=1, M completes, W, P, then IDLE; with PERF_CNT_EN, inst_cnt increments by 1.
